pipe_ctrl: RTL and testbench

//  Central stall/flush controller for the 5-stage pipeline registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_ctrl_pkg.sv | 63 ++++++
 rtl/pipe_ctrl_mdu_timer.sv | 39 +++
 rtl/pipe_ctrl.sv | 122 ++++++++++++
 tb/tb_pipe_ctrl.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
//   Shared definitions for the pipeline stall/flush controller:
//   FSM state encoding, the hardwired-zero register index, default
//   parameter values, and the bundle of per-stage hold/clear controls.
package pipe_ctrl_pkg;

  localparam int RA_W_DEF    = 5;
  localparam int MDU_LAT_DEF = 32;
  localparam int CNT_W_DEF   = 6;

  // GPR index that is hardwired to zero; writes to it never create a hazard.
  localparam int ZERO_REG = 0;

  typedef enum logic {
    RUN = 1'b0,
    LU2 = 1'b1
  } state_t;

  typedef struct packed {
    logic pc_hold;
    logic ifid_hold;
    logic idex_hold;
    logic exmem_hold;
    logic ifid_clear;
    logic idex_clear;
    logic memwb_clear;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  // Front end frozen, bubble injected into EX.
  function automatic ctrl_t stall_ctrl();
    ctrl_t c;
    c            = CTRL_IDLE;
    c.pc_hold    = 1'b1;
    c.ifid_hold  = 1'b1;
    c.idex_clear = 1'b1;
    return c;
  endfunction

  // Data memory not ready: everything up to EX/MEM holds, WB gets a bubble.
  function automatic ctrl_t freeze_ctrl();
    ctrl_t c;
    c             = CTRL_IDLE;
    c.pc_hold     = 1'b1;
    c.ifid_hold   = 1'b1;
    c.idex_hold   = 1'b1;
    c.exmem_hold  = 1'b1;
    c.memwb_clear = 1'b1;
    return c;
  endfunction

  // Applied while reset is asserted: flush every stage that has a clear input.
  function automatic ctrl_t reset_ctrl();
    ctrl_t c;
    c             = CTRL_IDLE;
    c.ifid_clear  = 1'b1;
    c.idex_clear  = 1'b1;
    c.memwb_clear = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/pipe_ctrl_mdu_timer.sv
// mdu_timer
//   Down-counter tracking how long the multi-cycle MDU stays busy.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset (counter -> 0)
//     load       : MDU start; reloads the counter to LAT-1 (restart if busy)
//     en         : advance enable; low freezes the counter entirely
//     cnt        : current remaining count
//     busy       : cnt != 0
module mdu_timer
  import pipe_ctrl_pkg::*;
#(
  parameter int LAT   = MDU_LAT_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             busy
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(LAT - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (en) begin
      if (load) begin
        cnt <= RELOAD;
      end else if (cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl
//   Central stall/flush controller for the 5-stage pipeline registers.
//   Detects load-use and branch-operand hazards, tracks the MDU busy window
//   and the data-memory wait, and drives per-stage hold/clear. Hold and clear
//   are never asserted on the same stage in the same cycle.
//   Ports:
//     clk, rst_n                 : clock, asynchronous active-low reset
//     id_rs, id_rt               : source registers of the ID instruction
//     id_uses_rs, id_uses_rt     : ID instruction actually reads rs / rt
//     id_branch, id_br_taken     : ID branch, and its taken resolution
//     id_mdu_use                 : ID instruction needs HI/LO or the MDU
//     ex_load, ex_wr, ex_wa      : EX instruction is a load / writes GPR ex_wa
//     ex_mdu_start               : EX instruction starts the MDU
//     mem_wait                   : data memory not ready
//     pc_hold .. exmem_hold      : stage holds
//     ifid_clear .. memwb_clear  : stage clears (bubbles)
//     mdu_busy                   : MDU counter non-zero
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int RA_W    = RA_W_DEF,
  parameter int MDU_LAT = MDU_LAT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [RA_W-1:0] id_rs,
  input  logic [RA_W-1:0] id_rt,
  input  logic            id_uses_rs,
  input  logic            id_uses_rt,
  input  logic            id_branch,
  input  logic            id_br_taken,
  input  logic            id_mdu_use,
  input  logic            ex_load,
  input  logic            ex_wr,
  input  logic [RA_W-1:0] ex_wa,
  input  logic            ex_mdu_start,
  input  logic            mem_wait,
  output logic            pc_hold,
  output logic            ifid_hold,
  output logic            idex_hold,
  output logic            exmem_hold,
  output logic            ifid_clear,
  output logic            idex_clear,
  output logic            memwb_clear,
  output logic            mdu_busy
);

  state_t           state;
  logic [CNT_W-1:0] mdu_cnt;
  logic             hz;
  logic             mdu_stall;
  logic             lu_stall;
  logic             br_stall;
  ctrl_t            ctrl;

  function automatic logic raw(input logic            wr,
                               input logic [RA_W-1:0] wa,
                               input logic [RA_W-1:0] a);
    return wr && (wa != RA_W'(ZERO_REG)) && (a == wa);
  endfunction

  assign hz = (id_uses_rs && raw(ex_wr, ex_wa, id_rs)) ||
              (id_uses_rt && raw(ex_wr, ex_wa, id_rt));

  assign mdu_stall = mdu_busy && id_mdu_use;
  assign lu_stall  = hz && ex_load;
  // A branch compares in ID, so even an ALU result still in EX is too late.
  assign br_stall  = hz && id_branch;

  mdu_timer #(
    .LAT   (MDU_LAT),
    .CNT_W (CNT_W)
  ) u_mdu_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (ex_mdu_start),
    .en    (!mem_wait),
    .cnt   (mdu_cnt),
    .busy  (mdu_busy)
  );

  // A branch that needs a load result waits one more cycle in LU2 while the
  // load moves from MEM to WB. Higher-priority stalls suppress the transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else if (!mem_wait) begin
      unique case (state)
        LU2:     state <= RUN;
        default: state <= (!mdu_stall && lu_stall && id_branch) ? LU2 : RUN;
      endcase
    end
  end

  // Priority chain; any stall masks id_br_taken since the branch re-resolves.
  always_comb begin
    ctrl = CTRL_IDLE;
    if (!rst_n) begin
      ctrl = reset_ctrl();
    end else if (mem_wait) begin
      ctrl = freeze_ctrl();
    end else if ((state == LU2) || mdu_stall || lu_stall || br_stall) begin
      ctrl = stall_ctrl();
    end else if (id_br_taken) begin
      ctrl.ifid_clear = 1'b1;
    end
  end

  assign pc_hold     = ctrl.pc_hold;
  assign ifid_hold   = ctrl.ifid_hold;
  assign idex_hold   = ctrl.idex_hold;
  assign exmem_hold  = ctrl.exmem_hold;
  assign ifid_clear  = ctrl.ifid_clear;
  assign idex_clear  = ctrl.idex_clear;
  assign memwb_clear = ctrl.memwb_clear;

  // The counter can never exceed its reload value.
  a_cnt_range: assert property (@(posedge clk) disable iff (!rst_n)
                                mdu_cnt <= CNT_W'(MDU_LAT - 1));

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

  localparam int RA_W    = 5;
  localparam int MDU_LAT = 32;
  localparam int CNT_W   = 6;

  // Output vector order:
  // [7] pc_hold [6] ifid_hold [5] idex_hold [4] exmem_hold
  // [3] ifid_clear [2] idex_clear [1] memwb_clear [0] mdu_busy
  localparam logic [7:0] O_RST    = 8'b0000_1110;
  localparam logic [7:0] O_STALL  = 8'b1100_0100;
  localparam logic [7:0] O_STALLB = 8'b1100_0101;
  localparam logic [7:0] O_FRZB   = 8'b1111_0011;
  localparam logic [7:0] O_BRT    = 8'b0000_1000;
  localparam logic [7:0] O_IDLE   = 8'b0000_0000;
  localparam logic [7:0] O_BUSY   = 8'b0000_0001;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [RA_W-1:0] id_rs, id_rt, ex_wa;
  logic            id_uses_rs, id_uses_rt, id_branch, id_br_taken, id_mdu_use;
  logic            ex_load, ex_wr, ex_mdu_start, mem_wait;
  logic            pc_hold, ifid_hold, idex_hold, exmem_hold;
  logic            ifid_clear, idex_clear, memwb_clear, mdu_busy;
  logic [7:0]      outs;
  logic [7:0]      exp;

  int ncmp  = 0;
  int nfail = 0;

  // Reference model state: remaining MDU busy cycles and pending second stall.
  int m_cnt = 0;
  bit m_lu2 = 1'b0;

  always #5 clk = ~clk;

  pipe_ctrl #(.RA_W(RA_W), .MDU_LAT(MDU_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_branch(id_branch), .id_br_taken(id_br_taken), .id_mdu_use(id_mdu_use),
    .ex_load(ex_load), .ex_wr(ex_wr), .ex_wa(ex_wa), .ex_mdu_start(ex_mdu_start),
    .mem_wait(mem_wait),
    .pc_hold(pc_hold), .ifid_hold(ifid_hold), .idex_hold(idex_hold), .exmem_hold(exmem_hold),
    .ifid_clear(ifid_clear), .idex_clear(idex_clear), .memwb_clear(memwb_clear),
    .mdu_busy(mdu_busy)
  );

  assign outs = {pc_hold, ifid_hold, idex_hold, exmem_hold,
                 ifid_clear, idex_clear, memwb_clear, mdu_busy};

  task automatic clr_in();
    id_rs = '0; id_rt = '0; ex_wa = '0;
    id_uses_rs = 0; id_uses_rt = 0; id_branch = 0; id_br_taken = 0; id_mdu_use = 0;
    ex_load = 0; ex_wr = 0; ex_mdu_start = 0; mem_wait = 0;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // Load in EX writing r8, branch in ID reading r8.
  task automatic set_lw_branch();
    ex_load = 1; ex_wr = 1; ex_wa = 5'd8;
    id_rs = 5'd8; id_uses_rs = 1; id_branch = 1;
  endtask

  // ---------------- behavioural reference ----------------
  function automatic bit m_hz();
    bit hit_rs, hit_rt;
    hit_rs = id_uses_rs && ex_wr && (ex_wa != 0) && (id_rs == ex_wa);
    hit_rt = id_uses_rt && ex_wr && (ex_wa != 0) && (id_rt == ex_wa);
    return hit_rs || hit_rt;
  endfunction

  function automatic logic [7:0] m_out();
    bit busy, stall;
    busy = (m_cnt > 0);
    if (!rst_n) return O_RST;
    if (mem_wait) return {7'b1111_001, busy};
    stall = m_lu2 || (busy && id_mdu_use) || (m_hz() && (ex_load || id_branch));
    if (stall) return {7'b1100_010, busy};
    if (id_br_taken) return {7'b0000_100, busy};
    return {7'b0, busy};
  endfunction

  task automatic m_step();
    bit busy, nxt_lu2;
    busy = (m_cnt > 0);
    if (!rst_n) begin
      m_cnt = 0; m_lu2 = 0;
    end else if (!mem_wait) begin
      nxt_lu2 = !m_lu2 && !(busy && id_mdu_use) && m_hz() && ex_load && id_branch;
      if (ex_mdu_start) m_cnt = MDU_LAT - 1;
      else if (m_cnt > 0) m_cnt = m_cnt - 1;
      m_lu2 = nxt_lu2;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clr_in();
    rst_n = 0;
    @(negedge clk);
    ncmp++;
    if (outs !== O_RST) begin
      nfail++; $display("FAIL reset_initial: got %b want %b", outs, O_RST);
    end
    next_cyc();
    rst_n = 1;
    ex_mdu_start = 1;                        // t0
    @(negedge clk);
    ncmp++;
    if (outs !== O_IDLE) begin
      nfail++; $display("FAIL reset_mdu_t0: got %b want %b", outs, O_IDLE);
    end
    next_cyc();
    ex_mdu_start = 0;
    for (int k = 1; k <= 20; k++) begin      // cnt 31..12
      @(negedge clk);
      ncmp++;
      if (outs !== O_BUSY) begin
        nfail++; $display("FAIL reset_busy_t%0d: got %b want %b", k, outs, O_BUSY);
      end
      next_cyc();
    end
    set_lw_branch();                         // t21, cnt=11
    @(negedge clk);
    ncmp++;
    if (outs !== O_STALLB) begin
      nfail++; $display("FAIL reset_lu1: got %b want %b", outs, O_STALLB);
    end
    next_cyc();
    clr_in();                                // t22: LU2, cnt=10
    @(negedge clk);
    ncmp++;
    if (outs !== O_STALLB) begin
      nfail++; $display("FAIL reset_lu2: got %b want %b", outs, O_STALLB);
    end
    #1 rst_n = 0;
    #1;
    ncmp++;
    if (outs !== O_RST) begin
      nfail++; $display("FAIL reset_async: got %b want %b", outs, O_RST);
    end
    next_cyc();
    rst_n = 1;
    id_mdu_use = 1;
    @(negedge clk);
    ncmp++;
    if (outs !== O_IDLE) begin
      nfail++; $display("FAIL reset_release: got %b want %b", outs, O_IDLE);
    end
    next_cyc();
    clr_in();
  endtask

  task automatic test_load_use();
    clr_in();
    ex_load = 1; ex_wr = 1; ex_wa = 5'd8; id_rs = 5'd8; id_uses_rs = 1;
    @(negedge clk);
    ncmp++;
    if (outs !== O_STALL) begin
      nfail++; $display("FAIL lu_rs_stall: got %b want %b", outs, O_STALL);
    end
    next_cyc();
    ex_load = 0; ex_wr = 0;                  // bubble now in EX
    @(negedge clk);
    ncmp++;
    if (outs !== O_IDLE) begin
      nfail++; $display("FAIL lu_rs_clean: got %b want %b", outs, O_IDLE);
    end
    next_cyc();
    clr_in();
    ex_load = 1; ex_wr = 1; ex_wa = 5'd17; id_rt = 5'd17; id_uses_rt = 1; id_rs = 5'd17;
    @(negedge clk);
    ncmp++;
    if (outs !== O_STALL) begin
      nfail++; $display("FAIL lu_rt_stall: got %b want %b", outs, O_STALL);
    end
    next_cyc();
    id_uses_rt = 0;                          // matching reg but not read
    @(negedge clk);
    ncmp++;
    if (outs !== O_IDLE) begin
      nfail++; $display("FAIL lu_unused_src: got %b want %b", outs, O_IDLE);
    end
    next_cyc();
    clr_in();
    ex_wr = 1; ex_wa = 5'd3; id_rs = 5'd3; id_uses_rs = 1;   // ALU hazard, forwarded
    @(negedge clk);
    ncmp++;
    if (outs !== O_IDLE) begin
      nfail++; $display("FAIL alu_no_stall: got %b want %b", outs, O_IDLE);
    end
    next_cyc();
    clr_in();
  endtask

  task automatic test_branch_after_load();
    clr_in();
    set_lw_branch();
    id_br_taken = 1;
    @(negedge clk);
    ncmp++;
    if (outs !== O_STALL) begin
      nfail++; $display("FAIL beq_lw_stall1: got %b want %b", outs, O_STALL);
    end
    next_cyc();
    ex_load = 0; ex_wr = 0; ex_wa = '0;
    @(negedge clk);
    ncmp++;
    if (outs !== O_STALL) begin
      nfail++; $display("FAIL beq_lw_stall2: got %b want %b", outs, O_STALL);
    end
    next_cyc();
    @(negedge clk);
    ncmp++;
    if (outs !== O_BRT) begin
      nfail++; $display("FAIL beq_lw_taken: got %b want %b", outs, O_BRT);
    end
    next_cyc();
    clr_in();
    ex_wr = 1; ex_wa = 5'd9; id_rt = 5'd9; id_uses_rt = 1; id_branch = 1; id_br_taken = 1;
    @(negedge clk);
    ncmp++;
    if (outs !== O_STALL) begin
      nfail++; $display("FAIL beq_alu_stall: got %b want %b", outs, O_STALL);
    end
    next_cyc();
    ex_wr = 0;
    @(negedge clk);
    ncmp++;
    if (outs !== O_BRT) begin
      nfail++; $display("FAIL beq_alu_taken: got %b want %b", outs, O_BRT);
    end
    next_cyc();
    clr_in();
  endtask

  task automatic test_zero_reg();
    clr_in();
    ex_load = 1; ex_wr = 1; ex_wa = '0; id_rs = '0; id_uses_rs = 1;
    id_rt = '0; id_uses_rt = 1; id_branch = 1;
    @(negedge clk);
    ncmp++;
    if (outs !== O_IDLE) begin
      nfail++; $display("FAIL zero_reg: got %b want %b", outs, O_IDLE);
    end
    next_cyc();
    clr_in();
  endtask

  task automatic test_mdu_release();
    clr_in();
    ex_mdu_start = 1; id_mdu_use = 1;
    @(negedge clk);
    ncmp++;
    if (outs !== O_IDLE) begin
      nfail++; $display("FAIL mdu_t0: got %b want %b", outs, O_IDLE);
    end
    next_cyc();
    ex_mdu_start = 0;
    for (int k = 1; k <= MDU_LAT - 1; k++) begin
      @(negedge clk);
      ncmp++;
      if (outs !== O_STALLB) begin
        nfail++; $display("FAIL mdu_stall_t%0d: got %b want %b", k, outs, O_STALLB);
      end
      next_cyc();
    end
    @(negedge clk);
    ncmp++;
    if (outs !== O_IDLE) begin
      nfail++; $display("FAIL mdu_release: got %b want %b", outs, O_IDLE);
    end
    next_cyc();
    clr_in();
  endtask

  task automatic test_mem_wait_freeze();
    clr_in();
    ex_mdu_start = 1;                        // t0
    @(negedge clk);
    ncmp++;
    if (outs !== O_IDLE) begin
      nfail++; $display("FAIL frz_t0: got %b want %b", outs, O_IDLE);
    end
    next_cyc();
    ex_mdu_start = 0;
    set_lw_branch();                         // t1, cnt=31
    @(negedge clk);
    ncmp++;
    if (outs !== O_STALLB) begin
      nfail++; $display("FAIL frz_lu1: got %b want %b", outs, O_STALLB);
    end
    next_cyc();
    clr_in();
    mem_wait = 1; id_br_taken = 1;           // t2..t4, LU2 and cnt=30 frozen
    for (int k = 0; k < 3; k++) begin
      ex_mdu_start = (k == 1);               // a start during the freeze is ignored
      @(negedge clk);
      ncmp++;
      if (outs !== O_FRZB) begin
        nfail++; $display("FAIL frz_wait%0d: got %b want %b", k, outs, O_FRZB);
      end
      next_cyc();
    end
    clr_in();                                // t5: LU2 resumes
    @(negedge clk);
    ncmp++;
    if (outs !== O_STALLB) begin
      nfail++; $display("FAIL frz_lu2_resume: got %b want %b", outs, O_STALLB);
    end
    next_cyc();
    id_mdu_use = 1;                          // t6..t34 stalled, cnt 29..1
    for (int k = 6; k <= 34; k++) begin
      @(negedge clk);
      ncmp++;
      if (outs !== O_STALLB) begin
        nfail++; $display("FAIL frz_mdu_t%0d: got %b want %b", k, outs, O_STALLB);
      end
      next_cyc();
    end
    @(negedge clk);
    ncmp++;
    if (outs !== O_IDLE) begin
      nfail++; $display("FAIL frz_mdu_release: got %b want %b", outs, O_IDLE);
    end
    next_cyc();
    clr_in();
  endtask

  task automatic test_random();
    m_cnt = 0; m_lu2 = 0;
    for (int n = 0; n < 1500; n++) begin
      rst_n        = ($urandom_range(0, 199) != 0);
      id_rs        = RA_W'($urandom_range(0, 3));
      id_rt        = RA_W'($urandom_range(0, 3));
      ex_wa        = RA_W'($urandom_range(0, 3));
      id_uses_rs   = $urandom_range(0, 1);
      id_uses_rt   = $urandom_range(0, 1);
      id_branch    = ($urandom_range(0, 3) == 0);
      id_br_taken  = ($urandom_range(0, 2) == 0);
      id_mdu_use   = ($urandom_range(0, 2) == 0);
      ex_load      = ($urandom_range(0, 2) == 0);
      ex_wr        = $urandom_range(0, 1);
      ex_mdu_start = ($urandom_range(0, 29) == 0);
      mem_wait     = ($urandom_range(0, 6) == 0);
      @(negedge clk);
      exp = m_out();
      ncmp++;
      if (outs !== exp) begin
        nfail++; $display("FAIL random_cyc%0d: got %b want %b", n, outs, exp);
      end
      m_step();
      next_cyc();
    end
    rst_n = 1;
    clr_in();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch_after_load();
    test_zero_reg();
    test_mdu_release();
    test_mem_wait_freeze();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule
